// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared state encoding and default field widths for the SPI link
package spi_pkg;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] SHIFT    = 2'd1;
  localparam logic [1:0] WAIT_END = 2'd2;
  localparam logic [1:0] DRAIN    = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE     = IDLE,
    ST_SHIFT    = SHIFT,
    ST_WAIT_END = WAIT_END,
    ST_DRAIN    = DRAIN
  } state_e;

  // Field widths shared with the SPI master.
  localparam int SPI_ADDR_BITS = 8;
  localparam int SPI_DATA_BITS = 16;

endpackage

// File: rtl/spi_rx_slave_if.sv
// rtl/spi_rx_slave_if.sv - serial pins and received-word outputs of spi_rx_slave
interface spi_rx_slave_if
  import spi_pkg::*;
#(
  parameter int ADDR_BITS = SPI_ADDR_BITS,
  parameter int DATA_BITS = SPI_DATA_BITS
);
  logic                 SEN;
  logic                 SCLK;
  logic                 SDATA;
  logic [ADDR_BITS-1:0] address_o;
  logic [DATA_BITS-1:0] data_o;
  logic                 valid_o;
  logic                 frame_err;
  logic                 busy;

  modport slave (
    input  SEN, SCLK, SDATA,
    output address_o, data_o, valid_o, frame_err, busy
  );

  modport master (
    output SEN, SCLK, SDATA,
    input  address_o, data_o, valid_o, frame_err, busy
  );
endinterface

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-flop synchronizer with rise/fall detect; resets to idle-high
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign q_o    = sync_q[SYNC_STAGES-1];
  assign rise_o = q_o & ~prev_q;
  assign fall_o = ~q_o & prev_q;
endmodule

// File: rtl/spi_rx_slave.sv
// rtl/spi_rx_slave.sv - CPOL0/CPHA0 receive-only SPI slave; SPI_RX_TIMEOUT_EN adds a stall abort
module spi_rx_slave
  import spi_pkg::*;
#(
  parameter int DATA_BITS      = SPI_DATA_BITS,
  parameter int ADDR_BITS      = SPI_ADDR_BITS,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic           clk,
  input logic           reset,
  spi_rx_slave_if.slave bus
);
  localparam int FRAME_BITS = ADDR_BITS + DATA_BITS;
  localparam int CNT_W      = $clog2(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_BITS - 1);

  logic sen_sync, sen_rise, sen_fall;
  logic sclk_sync, sclk_rise, sclk_fall;
  logic sdata_sync, sdata_rise, sdata_fall;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sen (
    .clk(clk), .reset(reset), .d_i(bus.SEN),
    .q_o(sen_sync), .rise_o(sen_rise), .fall_o(sen_fall)
  );
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sclk (
    .clk(clk), .reset(reset), .d_i(bus.SCLK),
    .q_o(sclk_sync), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sdata (
    .clk(clk), .reset(reset), .d_i(bus.SDATA),
    .q_o(sdata_sync), .rise_o(sdata_rise), .fall_o(sdata_fall)
  );

  logic unused_edges;
  assign unused_edges = &{1'b0, sclk_sync, sclk_fall, sdata_rise, sdata_fall};

  // The synchronizers reset to 1, so a SEN held low through reset looks like a fall.
  // Only honour sen_fall once the chain has flushed and SEN has been seen high.
  logic [SYNC_STAGES:0] settle_q;
  logic                 armed_q;
  logic                 sen_start;

  always_ff @(posedge clk) begin
    if (reset) begin
      settle_q <= '0;
      armed_q  <= 1'b0;
    end else begin
      settle_q <= {settle_q[SYNC_STAGES-1:0], 1'b1};
      armed_q  <= armed_q | (settle_q[SYNC_STAGES] & sen_sync);
    end
  end

  assign sen_start = sen_fall & armed_q;

  state_e                  state_q, state_d;
  logic [FRAME_BITS-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ADDR_BITS-1:0]    addr_q, addr_d;
  logic [DATA_BITS-1:0]    data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    err_q, err_d;
  logic                    busy_q;
  logic                    timeout;

`ifdef SPI_RX_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [IDLE_W-1:0] idle_q, idle_d;

  assign timeout = (idle_q == IDLE_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    idle_d = idle_q;
    if (state_q == ST_IDLE || sclk_rise) begin
      idle_d = '0;
    end else if (!timeout) begin
      idle_d = idle_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) idle_q <= '0;
    else       idle_q <= idle_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sen_start) begin
          shift_d = '0;
          cnt_d   = CNT_LAST;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // sen_rise wins over a coincident sclk_rise: that bit is dropped.
        if (sen_rise) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = ST_DRAIN;
        end else if (sclk_rise) begin
          shift_d = {shift_q[FRAME_BITS-2:0], sdata_sync};
          if (cnt_q == '0) state_d = ST_WAIT_END;
          else             cnt_d   = cnt_q - 1'b1;
        end
      end
      ST_WAIT_END: begin
        if (sen_rise) begin
          addr_d  = shift_q[FRAME_BITS-1 -: ADDR_BITS];
          data_d  = shift_q[DATA_BITS-1:0];
          valid_d = 1'b1;
          state_d = ST_IDLE;
        end else if (sclk_rise || timeout) begin
          err_d   = 1'b1;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (sen_rise) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  assign bus.address_o = addr_q;
  assign bus.data_o    = data_q;
  assign bus.valid_o   = valid_q;
  assign bus.frame_err = err_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_spi_rx_slave.sv
// tb/tb_spi_rx_slave.sv - directed and randomized frames against a frame-level outcome model
module tb_spi_rx_slave;
  localparam int AB = 8;
  localparam int DB = 16;
  localparam int FB = AB + DB;
  localparam int SS = 2;
  localparam int TO = 64;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  spi_rx_slave_if #(.ADDR_BITS(AB), .DATA_BITS(DB)) bus ();

  spi_rx_slave #(
    .DATA_BITS(DB), .ADDR_BITS(AB), .SYNC_STAGES(SS), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int n_vec = 0;
  int n_miss = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  int v_cnt = 0, e_cnt = 0, both_cnt = 0, v_cyc = 0, e_cyc = 0;
  logic [FB-1:0] cap_q[$];
  always @(negedge clk) begin
    if (bus.valid_o === 1'b1) begin
      v_cnt++;
      v_cyc = cyc;
      cap_q.push_back({bus.address_o, bus.data_o});
    end
    if (bus.frame_err === 1'b1) begin
      e_cnt++;
      e_cyc = cyc;
    end
    if (bus.valid_o === 1'b1 && bus.frame_err === 1'b1) both_cnt++;
  end

  // Reference: last successfully received word; outputs must hold it between frames.
  logic [AB-1:0] m_addr = '0;
  logic [DB-1:0] m_data = '0;
  int last_rise_cyc = 0;
  int sen_rise_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sen_low(input int half);
    @(negedge clk);
    bus.SEN = 1'b0;
    wait_cyc(half);
  endtask

  task automatic send_bits(input logic [FB-1:0] word, input int first, input int n, input int half);
    for (int i = first; i < first + n; i++) begin
      if (i < FB) bus.SDATA = word[FB-1-i];
      else        bus.SDATA = 1'($urandom);
      wait_cyc(half);
      bus.SCLK = 1'b1;
      last_rise_cyc = cyc;
      wait_cyc(half);
      bus.SCLK = 1'b0;
    end
  endtask

  task automatic sen_high(input int half);
    wait_cyc(half);
    bus.SEN = 1'b1;
    bus.SDATA = 1'b0;
    sen_rise_cyc = cyc;
  endtask

  task automatic run_frame(input string tag, input logic [FB-1:0] word, input int nbits,
                           input int half, input int gap);
    int v0, e0, lat, exp_v;
    v0 = v_cnt;
    e0 = e_cnt;
    exp_v = (nbits == FB) ? 1 : 0;
    sen_low(half);
    chk({tag, "_busy_mid"}, 32'(bus.busy), 1);
    send_bits(word, 0, nbits, half);
    sen_high(half);
    wait_cyc(gap + 8);
    if (exp_v == 1) begin
      m_addr = word[FB-1 -: AB];
      m_data = word[DB-1:0];
    end
    chk({tag, "_valid_cnt"}, 32'(v_cnt - v0), 32'(exp_v));
    chk({tag, "_err_cnt"}, 32'(e_cnt - e0), 32'(1 - exp_v));
    if (v_cnt - v0 == 1) begin
      lat = v_cyc - sen_rise_cyc;
      chk({tag, "_valid_lat_2to4"}, 32'(lat >= 2 && lat <= 4), 1);
    end
    chk({tag, "_addr"}, 32'(bus.address_o), 32'(m_addr));
    chk({tag, "_data"}, 32'(bus.data_o), 32'(m_data));
    chk({tag, "_busy_end"}, 32'(bus.busy), 0);
  endtask

  initial begin
    int v0, e0, c0, lat, nbits, r;
    logic [FB-1:0] w;

    reset = 1'b1;
    bus.SEN = 1'b1;
    bus.SCLK = 1'b0;
    bus.SDATA = 1'b0;
    wait_cyc(3);
    chk("rst_addr", 32'(bus.address_o), 0);
    chk("rst_data", 32'(bus.data_o), 0);
    chk("rst_valid", 32'(bus.valid_o), 0);
    chk("rst_err", 32'(bus.frame_err), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    reset = 1'b0;
    wait_cyc(8);

    run_frame("normal", {8'hA5, 16'h3C7E}, FB, 4, 4);

    // Back-to-back with 4 clk of SEN high between frames.
    v0 = v_cnt;
    c0 = cap_q.size();
    sen_low(4);
    send_bits({8'h01, 16'hFFFF}, 0, FB, 4);
    sen_high(4);
    wait_cyc(4);
    bus.SEN = 1'b0;
    wait_cyc(4);
    send_bits({8'h80, 16'h0001}, 0, FB, 4);
    sen_high(4);
    wait_cyc(10);
    m_addr = 8'h80;
    m_data = 16'h0001;
    chk("b2b_valid_cnt", 32'(v_cnt - v0), 2);
    if (cap_q.size() - c0 == 2) begin
      chk("b2b_first", 32'(cap_q[c0]), 32'({8'h01, 16'hFFFF}));
      chk("b2b_second", 32'(cap_q[c0+1]), 32'({8'h80, 16'h0001}));
    end
    chk("b2b_addr", 32'(bus.address_o), 32'(m_addr));

    run_frame("short10", 24'h123456, 10, 4, 4);
    run_frame("long25", 24'hFEDCBA, FB + 1, 4, 4);

    // Reset mid-frame while SEN stays low.
    v0 = v_cnt;
    e0 = e_cnt;
    w = 24'h5AA55A;
    sen_low(4);
    send_bits(w, 0, 12, 4);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", 32'(bus.busy), 0);
    chk("mid_rst_addr", 32'(bus.address_o), 0);
    chk("mid_rst_data", 32'(bus.data_o), 0);
    chk("mid_rst_valid", 32'(bus.valid_o), 0);
    chk("mid_rst_err", 32'(bus.frame_err), 0);
    reset = 1'b0;
    m_addr = '0;
    m_data = '0;
    send_bits(w, 12, 12, 4);
    chk("mid_rst_ignored_busy", 32'(bus.busy), 0);
    sen_high(4);
    wait_cyc(10);
    chk("mid_rst_no_valid", 32'(v_cnt - v0), 0);
    chk("mid_rst_no_err", 32'(e_cnt - e0), 0);
    run_frame("after_rst", {8'h3C, 16'hC0DE}, FB, 4, 4);

    // SCLK stalls after 5 bits.
    v0 = v_cnt;
    e0 = e_cnt;
    sen_low(4);
    send_bits(24'hABCDEF, 0, 5, 4);
    wait_cyc(TO + 40);
`ifdef SPI_RX_TIMEOUT_EN
    chk("stall_err", 32'(e_cnt - e0), 1);
    lat = e_cyc - last_rise_cyc;
    chk("stall_err_lat", 32'(lat >= TO && lat <= TO + 4), 1);
`else
    chk("stall_no_err", 32'(e_cnt - e0), 0);
    chk("stall_busy", 32'(bus.busy), 1);
`endif
    sen_high(4);
    wait_cyc(10);
    chk("stall_no_valid", 32'(v_cnt - v0), 0);
    chk("stall_err_total", 32'(e_cnt - e0), 1);
    chk("stall_busy_end", 32'(bus.busy), 0);

    for (int k = 0; k < 12; k++) begin
      r = int'($urandom_range(0, 9));
      if (r < 6)      nbits = FB;
      else if (r < 8) nbits = int'($urandom_range(0, FB - 1));
      else            nbits = FB + int'($urandom_range(1, 3));
      w = FB'($urandom);
      run_frame($sformatf("rnd%0d_n%0d", k, nbits), w, nbits,
                int'($urandom_range(4, 6)), int'($urandom_range(4, 8)));
    end

    chk("valid_err_overlap", 32'(both_cnt), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
